// File: rtl/lcd_rx_pkg.sv
// Shared opcodes, receiver state encoding and default display geometry for the
// LCD serial write-link receiver.
package lcd_rx_pkg;

    localparam int PAGE_W_DEF = 3;
    localparam int COL_W_DEF  = 7;

    localparam logic [7:0] CMD_PAGE_BASE = 8'hB0;
    localparam logic [7:0] CMD_COLH_BASE = 8'h10;
    localparam logic [7:0] CMD_COLL_BASE = 8'h00;
    localparam logic [7:0] CMD_DISP_OFF  = 8'hAE;
    localparam logic [7:0] CMD_DISP_ON   = 8'hAF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DECODE = 2'd2
    } rx_state_t;

    // Page select covers B0..B7; the low three bits carry the page.
    function automatic logic is_page_cmd(input logic [7:0] b);
        return (b & 8'hF8) == CMD_PAGE_BASE;
    endfunction

    function automatic logic is_colh_cmd(input logic [7:0] b);
        return (b & 8'hF0) == CMD_COLH_BASE;
    endfunction

    function automatic logic is_coll_cmd(input logic [7:0] b);
        return (b & 8'hF0) == CMD_COLL_BASE;
    endfunction

endpackage

// File: rtl/lcd_spi_deser.sv
// Serial byte deserialiser: sck rise detect, MSB-first shift register and cs framing.
// With LCD_SERIAL_RX_ERR_EN defined it also flags cs rising mid-byte.
module lcd_spi_deser
    import lcd_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       sda,
    input  logic       rs,
    input  logic       cs,
    output logic       byte_vld,
    output logic [7:0] rx_byte,
    output logic       rs_lat
`ifdef LCD_SERIAL_RX_ERR_EN
    ,
    output logic       frame_err
`endif
);

    logic      sck_q;
    logic [2:0] bit_cnt;
    logic [6:0] shift;
    rx_state_t state;

    logic rise_s;
    logic last_bit_s;

    assign rise_s     = sck & ~sck_q & ~cs;
    assign last_bit_s = rise_s && (bit_cnt == 3'd7);

    // Completed byte is presented in the cycle its 8th bit is sampled, so the
    // decoder can register its strobes on that same edge.
    always_comb begin
        byte_vld = last_bit_s;
        rx_byte  = {shift, sda};
        rs_lat   = rs;
    end

`ifdef LCD_SERIAL_RX_ERR_EN
    // cs high is only seen with a non-zero count on the first cycle of a mid-byte abort
    always_comb begin
        frame_err = cs && (bit_cnt != 3'd0);
    end
`endif

    // Edge detect, shift register, bit counter and framing state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_q   <= 1'b0;
            bit_cnt <= 3'd0;
            shift   <= 7'd0;
            state   <= ST_IDLE;
        end else begin
            sck_q <= sck;
            if (cs) begin
                bit_cnt <= 3'd0;
                shift   <= 7'd0;
                state   <= ST_IDLE;
            end else begin
                // A rise is accepted in every state so one landing on DECODE is not lost.
                if (rise_s) begin
                    shift   <= {shift[5:0], sda};
                    bit_cnt <= last_bit_s ? 3'd0 : bit_cnt + 3'd1;
                end else begin
                    bit_cnt <= bit_cnt;
                end
                case (state)
                    ST_IDLE:   state <= ST_SHIFT;
                    ST_SHIFT:  state <= last_bit_s ? ST_DECODE : ST_SHIFT;
                    ST_DECODE: state <= ST_SHIFT;
                    default:   state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/lcd_serial_rx.sv
// LCD serial write-link receiver: decodes page/column commands, writes data bytes
// to a frame-buffer port with column auto-increment. Optional: LCD_SERIAL_RX_ERR_EN.
module lcd_serial_rx
    import lcd_rx_pkg::*;
#(
    parameter int PAGE_W = PAGE_W_DEF,
    parameter int COL_W  = COL_W_DEF
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      sck,
    input  logic                      sda,
    input  logic                      rs,
    input  logic                      cs,
    output logic                      fb_we,
    output logic [PAGE_W+COL_W-1:0]   fb_addr,
    output logic [7:0]                fb_data,
    output logic                      cmd_valid,
    output logic [7:0]                cmd_byte,
    output logic                      disp_on,
    output logic                      err_frame
);

    logic              byte_vld_s;
    logic [7:0]        rx_byte_s;
    logic              rs_lat_s;
    logic [PAGE_W-1:0] page_r;
    logic [COL_W-1:0]  col_r;

`ifdef LCD_SERIAL_RX_ERR_EN
    logic frame_err_s;
`endif

    lcd_spi_deser u_deser (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .sck      (sck),
        .sda      (sda),
        .rs       (rs),
        .cs       (cs),
        .byte_vld (byte_vld_s),
        .rx_byte  (rx_byte_s),
        .rs_lat   (rs_lat_s)
`ifdef LCD_SERIAL_RX_ERR_EN
        ,
        .frame_err(frame_err_s)
`endif
    );

    // Registered decode of each completed byte into writes, address updates and command strobes
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            fb_we     <= 1'b0;
            fb_addr   <= '0;
            fb_data   <= 8'd0;
            cmd_valid <= 1'b0;
            cmd_byte  <= 8'd0;
            disp_on   <= 1'b0;
            page_r    <= '0;
            col_r     <= '0;
        end else begin
            fb_we     <= 1'b0;
            cmd_valid <= 1'b0;
            if (byte_vld_s) begin
                if (rs_lat_s) begin
                    fb_we   <= 1'b1;
                    fb_addr <= {page_r, col_r};
                    fb_data <= rx_byte_s;
                    col_r   <= col_r + COL_W'(1);
                end else if (is_page_cmd(rx_byte_s)) begin
                    page_r <= rx_byte_s[PAGE_W-1:0];
                end else if (is_colh_cmd(rx_byte_s)) begin
                    // byte[3] is deliberately ignored: only three high column bits exist
                    col_r[COL_W-1:4] <= rx_byte_s[COL_W-5:0];
                end else if (is_coll_cmd(rx_byte_s)) begin
                    col_r[3:0] <= rx_byte_s[3:0];
                end else begin
                    cmd_valid <= 1'b1;
                    cmd_byte  <= rx_byte_s;
                    case (rx_byte_s)
                        CMD_DISP_OFF: disp_on <= 1'b0;
                        CMD_DISP_ON:  disp_on <= 1'b1;
                        default:      disp_on <= disp_on;
                    endcase
                end
            end else begin
                col_r <= col_r;
            end
        end
    end

`ifdef LCD_SERIAL_RX_ERR_EN
    // Sticky framing error, cleared only by reset
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            err_frame <= 1'b0;
        end else if (frame_err_s) begin
            err_frame <= 1'b1;
        end else begin
            err_frame <= err_frame;
        end
    end
`else
    assign err_frame = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_serial_rx.sv
// Directed bench for lcd_serial_rx: a byte-level model predicts every strobe,
// one compare process checks each strobe cycle, literals pin the model.
`timescale 1ns/1ps
module tb_lcd_serial_rx;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       sck, sda, rs, cs;
    logic       fb_we;
    logic [9:0] fb_addr;
    logic [7:0] fb_data;
    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       disp_on;
    logic       err_frame;

    lcd_serial_rx #(.PAGE_W(3), .COL_W(7)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .sck(sck), .sda(sda), .rs(rs), .cs(cs),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .disp_on(disp_on), .err_frame(err_frame)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Byte-level model of the display controller
    typedef struct {int addr; int data; int due;} fb_ev_t;
    typedef struct {int b; int disp; int due;} cmd_ev_t;
    fb_ev_t  fb_q[$];
    cmd_ev_t cmd_q[$];
    int m_page = 0, m_col = 0, m_disp = 0, m_err = 0;
    int seen_addr[$], seen_data[$], seen_cmd[$];
    int n_fb = 0, n_cmd = 0;

    task automatic model_reset();
        m_page = 0; m_col = 0; m_disp = 0; m_err = 0;
    endtask

    task automatic model_byte(input int b, input int is_data, input int due);
        if (is_data != 0) begin
            fb_q.push_back('{m_page * 128 + m_col, b, due});
            m_col = (m_col + 1) % 128;
        end else if (b >= 32'hB0 && b <= 32'hB7) begin
            m_page = b - 32'hB0;
        end else if (b >= 32'h10 && b <= 32'h1F) begin
            m_col = (b % 8) * 16 + (m_col % 16);
        end else if (b <= 32'h0F) begin
            m_col = (m_col / 16) * 16 + b;
        end else begin
            if (b == 32'hAE) m_disp = 0;
            else if (b == 32'hAF) m_disp = 1;
            cmd_q.push_back('{b, m_disp, due});
        end
    endtask

    // Compare process: every strobe must match the head of the model queue on its due cycle
    always @(negedge sys_clk) begin
        fb_ev_t  fe;
        cmd_ev_t ce;
        if (!sys_rst) begin
            if (fb_we) begin
                n_fb++;
                seen_addr.push_back(int'(fb_addr));
                seen_data.push_back(int'(fb_data));
                if (fb_q.size() == 0) check("fb_unexpected", 1, 0);
                else begin
                    fe = fb_q.pop_front();
                    check("fb_addr", int'(fb_addr), fe.addr);
                    check("fb_data", int'(fb_data), fe.data);
                    check("fb_latency", cyc, fe.due);
                end
            end else if (fb_q.size() != 0 && cyc > fb_q[0].due) begin
                check("fb_missing", 0, 1);
                void'(fb_q.pop_front());
            end
            if (cmd_valid) begin
                n_cmd++;
                seen_cmd.push_back(int'(cmd_byte));
                if (cmd_q.size() == 0) check("cmd_unexpected", 1, 0);
                else begin
                    ce = cmd_q.pop_front();
                    check("cmd_byte", int'(cmd_byte), ce.b);
                    check("cmd_disp_on", int'(disp_on), ce.disp);
                    check("cmd_latency", cyc, ce.due);
                end
            end else if (cmd_q.size() != 0 && cyc > cmd_q[0].due) begin
                check("cmd_missing", 0, 1);
                void'(cmd_q.pop_front());
            end
        end
    end

    task automatic send_bits(input logic [7:0] b, input logic rs_v, input int n);
        if (cs) begin
            @(negedge sys_clk) cs = 1'b0;
        end
        for (int i = 7; i > 7 - n; i--) begin
            @(negedge sys_clk);
            sck = 1'b0; sda = b[i]; rs = rs_v;
            @(negedge sys_clk);
            if (i == 0) model_byte(int'(b), int'(rs_v), cyc + 1);
            sck = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic rs_v, input logic rel);
        send_bits(b, rs_v, 8);
        if (rel) begin
            @(negedge sys_clk) sck = 1'b0;
            @(negedge sys_clk) cs = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        @(negedge sys_clk) sck = 1'b0;
        repeat (n) @(negedge sys_clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int order_err;
        sys_rst = 1'b1; sck = 1'b0; sda = 1'b0; rs = 1'b0; cs = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("rst_fb_we", int'(fb_we), 0);
        check("rst_fb_addr", int'(fb_addr), 0);
        check("rst_fb_data", int'(fb_data), 0);
        check("rst_cmd_valid", int'(cmd_valid), 0);
        check("rst_cmd_byte", int'(cmd_byte), 0);
        check("rst_disp_on", int'(disp_on), 0);
        check("rst_err_frame", int'(err_frame), 0);
        @(negedge sys_clk) sys_rst = 1'b0;
        idle(2);

        // Reset in the middle of a byte
        send_bits(8'h5A, 1'b1, 5);
        @(negedge sys_clk) begin sys_rst = 1'b1; sck = 1'b0; cs = 1'b1; end
        model_reset();
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        base = n_fb;
        seen_addr.delete(); seen_data.delete();
        send_byte(8'hA5, 1'b1, 1'b1);
        idle(4);
        check("rst_one_write", n_fb - base, 1);
        if (seen_addr.size() == 1) begin
            check("rst_addr_lit", seen_addr[0], 0);
            check("rst_data_lit", seen_data[0], 32'hA5);
        end

        // Address commands then two data bytes
        seen_addr.delete(); seen_data.delete(); base = n_cmd;
        send_byte(8'hB3, 1'b0, 1'b0);
        send_byte(8'h12, 1'b0, 1'b0);
        send_byte(8'h05, 1'b0, 1'b0);
        send_byte(8'hA5, 1'b1, 1'b0);
        send_byte(8'h3C, 1'b1, 1'b1);
        idle(4);
        check("addr_no_cmd", n_cmd - base, 0);
        check("addr_writes", seen_addr.size(), 2);
        if (seen_addr.size() == 2) begin
            check("addr421_lit", seen_addr[0], 421);
            check("data_a5_lit", seen_data[0], 32'hA5);
            check("addr422_lit", seen_addr[1], 422);
            check("data_3c_lit", seen_data[1], 32'h3C);
        end

        // Column wrap within page 7
        seen_addr.delete(); seen_data.delete();
        send_byte(8'hB7, 1'b0, 1'b0);
        send_byte(8'h17, 1'b0, 1'b0);
        send_byte(8'h0F, 1'b0, 1'b0);
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, 1'b1);
        idle(4);
        check("wrap_writes", seen_addr.size(), 2);
        if (seen_addr.size() == 2) begin
            check("addr1023_lit", seen_addr[0], 1023);
            check("addr896_lit", seen_addr[1], 896);
            check("wrap_data_lit", seen_data[1], 32'h22);
        end

        // Framing: cs raised after 5 bits, then a full command byte
        seen_cmd.delete(); base = n_cmd;
        send_bits(8'hFF, 1'b0, 5);
        @(negedge sys_clk) sck = 1'b0;
        @(negedge sys_clk) cs = 1'b1;
`ifdef LCD_SERIAL_RX_ERR_EN
        m_err = 1;
`endif
        idle(2);
        send_byte(8'hE2, 1'b0, 1'b1);
        idle(4);
        check("frame_one_cmd", n_cmd - base, 1);
        if (seen_cmd.size() == 1) check("frame_cmd_e2_lit", seen_cmd[0], 32'hE2);
        check("frame_err_model", int'(err_frame), m_err);
`ifdef LCD_SERIAL_RX_ERR_EN
        check("frame_err_lit", int'(err_frame), 1);
`else
        check("frame_err_lit", int'(err_frame), 0);
`endif

        // Display on/off
        seen_cmd.delete();
        send_byte(8'hAF, 1'b0, 1'b1);
        idle(3);
        check("disp_on_lit", int'(disp_on), 1);
        send_byte(8'hAE, 1'b0, 1'b1);
        idle(3);
        check("disp_off_lit", int'(disp_on), 0);
        check("disp_model", int'(disp_on), m_disp);
        if (seen_cmd.size() == 2) check("disp_cmd_af_lit", seen_cmd[0], 32'hAF);
        else check("disp_cmd_count", seen_cmd.size(), 2);

        // Full 1024-byte refresh with cs held low throughout
        seen_addr.delete(); base = n_fb;
        for (int p = 0; p < 8; p++) begin
            send_byte(8'(32'hB0 + p), 1'b0, 1'b0);
            send_byte(8'h10, 1'b0, 1'b0);
            send_byte(8'h00, 1'b0, 1'b0);
            for (int c = 0; c < 128; c++) begin
                send_byte(8'(((p * 128 + c) * 37 + 11) % 256), 1'b1,
                          (p == 7 && c == 127) ? 1'b1 : 1'b0);
            end
        end
        idle(4);
        check("stream_writes", n_fb - base, 1024);
        order_err = 0;
        foreach (seen_addr[i]) if (seen_addr[i] != i) order_err++;
        check("stream_order", order_err, 0);

        idle(4);
        check("fb_queue_drained", fb_q.size(), 0);
        check("cmd_queue_drained", cmd_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
